// File: rtl/vc_fifo.sv
// vc_fifo: NUM_VC independent circular FIFOs sharing one write and one read port.
// Define VC_FIFO_FWFT_EN for first-word fall-through reads; default is a registered 1-cycle read.
module vc_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH = 16,
  parameter int NUM_VC = 2,
  parameter int AF_THRESH = 14,
  localparam int VC_W = NUM_VC > 1 ? $clog2(NUM_VC) : 1,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCUP_W = PTR_W + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write_en,
  input  logic [VC_W-1:0]          write_vc,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     read_en,
  input  logic [VC_W-1:0]          read_vc,
  output logic [DATA_W-1:0]        data_out,
  output logic                     data_valid,
  output logic                     error,
  output logic [NUM_VC-1:0]        full,
  output logic [NUM_VC-1:0]        empty,
  output logic [NUM_VC-1:0]        almost_full,
  output logic [NUM_VC*OCUP_W-1:0] ocup
);
  logic [DATA_W-1:0] mem [NUM_VC*DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [NUM_VC];
  logic [PTR_W-1:0] wr_ptr_d [NUM_VC];
  logic [PTR_W-1:0] rd_ptr_q [NUM_VC];
  logic [PTR_W-1:0] rd_ptr_d [NUM_VC];
  logic [OCUP_W-1:0] ocup_q [NUM_VC];
  logic [OCUP_W-1:0] ocup_d [NUM_VC];
  logic [NUM_VC-1:0] full_q, full_d, empty_q, empty_d, af_q, af_d, wr_hit, rd_hit;
  logic error_q, error_d, wv_ok, rv_ok, wr_acc, rd_acc;
  logic [DATA_W-1:0] head;
  always_comb begin
    wv_ok = {1'b0, write_vc} < (VC_W+1)'(NUM_VC);
    rv_ok = {1'b0, read_vc} < (VC_W+1)'(NUM_VC);
    wr_acc = write_en && wv_ok && !full_q[write_vc];
    rd_acc = read_en && rv_ok && !empty_q[read_vc];
    error_d = (write_en && !wr_acc) || (read_en && !rd_acc);
    head = mem[{read_vc, rd_ptr_q[read_vc]}];
    for (int i = 0; i < NUM_VC; i++) begin
      wr_hit[i] = wr_acc && write_vc == VC_W'(i);
      rd_hit[i] = rd_acc && read_vc == VC_W'(i);
      wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(wr_hit[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(rd_hit[i]);
      ocup_d[i] = ocup_q[i] + OCUP_W'(wr_hit[i]) - OCUP_W'(rd_hit[i]);
      full_d[i] = ocup_d[i] == OCUP_W'(DEPTH);
      empty_d[i] = ocup_d[i] == '0;
      af_d[i] = ocup_d[i] >= OCUP_W'(AF_THRESH);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '{default: '0};
      rd_ptr_q <= '{default: '0};
      ocup_q <= '{default: '0};
      full_q <= '0;
      empty_q <= '1;
      af_q <= '0;
      error_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ocup_q <= ocup_d;
      full_q <= full_d;
      empty_q <= empty_d;
      af_q <= af_d;
      error_q <= error_d;
    end
  end
  // Storage is not reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) mem[{write_vc, wr_ptr_q[write_vc]}] <= data_in;
  end
`ifdef VC_FIFO_FWFT_EN
  assign data_valid = rv_ok && !empty_q[read_vc];
  assign data_out = data_valid ? head : '0;
`else
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic data_valid_q, data_valid_d;
  always_comb begin
    data_out_d = rd_acc ? head : data_out_q;
    data_valid_d = rd_acc;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end
  assign data_out = data_out_q;
  assign data_valid = data_valid_q;
`endif
  assign error = error_q;
  assign full = full_q;
  assign empty = empty_q;
  assign almost_full = af_q;
  for (genvar g = 0; g < NUM_VC; g++) begin : g_ocup
    assign ocup[g*OCUP_W +: OCUP_W] = ocup_q[g];
  end
endmodule

// File: tb/tb_vc_fifo.sv
// tb_vc_fifo: directed checks of vc_fifo (default 2-VC instance plus a 3-VC instance for out-of-range indices).
module tb_vc_fifo;
  logic clk = 1'b0, reset;
  logic write_en, read_en;
  logic [0:0] write_vc, read_vc;
  logic [63:0] data_in, data_out;
  logic data_valid, error;
  logic [1:0] full, empty, almost_full;
  logic [9:0] ocup;
  logic w3_en, r3_en;
  logic [1:0] w3_vc, r3_vc;
  logic [7:0] d3_in, d3_out;
  logic dv3, err3;
  logic [2:0] full3, empty3, af3;
  logic [8:0] ocup3;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  vc_fifo dut (
    .clk(clk), .reset(reset), .write_en(write_en), .write_vc(write_vc), .data_in(data_in),
    .read_en(read_en), .read_vc(read_vc), .data_out(data_out), .data_valid(data_valid),
    .error(error), .full(full), .empty(empty), .almost_full(almost_full), .ocup(ocup)
  );

  vc_fifo #(.DATA_W(8), .DEPTH(4), .NUM_VC(3), .AF_THRESH(3)) dut3 (
    .clk(clk), .reset(reset), .write_en(w3_en), .write_vc(w3_vc), .data_in(d3_in),
    .read_en(r3_en), .read_vc(r3_vc), .data_out(d3_out), .data_valid(dv3),
    .error(err3), .full(full3), .empty(empty3), .almost_full(af3), .ocup(ocup3)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] oc(input int v);
    return ocup[v*5 +: 5];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    write_en = 1'b0;
    read_en = 1'b0;
    w3_en = 1'b0;
    r3_en = 1'b0;
  endtask

  task automatic wr(input logic vc, input logic [63:0] d);
    write_en = 1'b1;
    write_vc = vc;
    data_in = d;
    tick();
    write_en = 1'b0;
  endtask

  task automatic rw(input logic vc, input logic [63:0] d, input logic [63:0] exp);
    write_en = 1'b1;
    write_vc = vc;
    data_in = d;
    read_vc = vc;
`ifdef VC_FIFO_FWFT_EN
    #1;
    chk("rw_data", data_out, exp);
    chk("rw_valid", 64'(data_valid), 64'd1);
`endif
    read_en = 1'b1;
    tick();
    idle();
`ifndef VC_FIFO_FWFT_EN
    chk("rw_data", data_out, exp);
    chk("rw_valid", 64'(data_valid), 64'd1);
`endif
  endtask

  task automatic rd(input logic vc, input logic [63:0] exp);
    read_vc = vc;
`ifdef VC_FIFO_FWFT_EN
    #1;
    chk("rd_data", data_out, exp);
    chk("rd_valid", 64'(data_valid), 64'd1);
`endif
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
`ifndef VC_FIFO_FWFT_EN
    chk("rd_data", data_out, exp);
    chk("rd_valid", 64'(data_valid), 64'd1);
`endif
  endtask

  task automatic chk_reset_state;
    chk("rst_empty", 64'(empty), 64'h3);
    chk("rst_full", 64'(full), 64'h0);
    chk("rst_af", 64'(almost_full), 64'h0);
    chk("rst_ocup", 64'(ocup), 64'h0);
    chk("rst_dv", 64'(data_valid), 64'h0);
    chk("rst_dout", data_out, 64'h0);
    chk("rst_err", 64'(error), 64'h0);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    write_vc = '0;
    read_vc = '0;
    data_in = '0;
    w3_vc = '0;
    r3_vc = '0;
    d3_in = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk_reset_state();

    wr(0, 64'hA5A5A5A5A5A5A5A5);
    chk("oc0_1", 64'(oc(0)), 64'd1);
    wr(0, 64'h00000000BBBBBBBB);
    chk("oc0_2", 64'(oc(0)), 64'd2);
    wr(0, 64'h00010001BBBBBBBB);
    chk("oc0_3", 64'(oc(0)), 64'd3);
    chk("vc1_empty", 64'(empty[1]), 64'd1);
    rd(0, 64'hA5A5A5A5A5A5A5A5);
    chk("oc0_r2", 64'(oc(0)), 64'd2);
    rd(0, 64'h00000000BBBBBBBB);
    chk("oc0_r1", 64'(oc(0)), 64'd1);
    rd(0, 64'h00010001BBBBBBBB);
    chk("oc0_r0", 64'(oc(0)), 64'd0);
    tick();
    chk("dv_drop", 64'(data_valid), 64'd0);
    chk("empty_after", 64'(empty), 64'h3);

    wr(0, 64'h10);
    wr(1, 64'h20);
    wr(0, 64'h11);
    wr(1, 64'h21);
    chk("il_oc1", 64'(oc(1)), 64'd2);
    rd(1, 64'h20);
    rd(0, 64'h10);
    rd(1, 64'h21);
    rd(0, 64'h11);
    chk("il_empty", 64'(empty), 64'h3);

    for (int i = 0; i < 16; i++) begin
      wr(0, 64'(100 + i));
      chk("af_step", 64'(almost_full[0]), 64'(i + 1 >= 14));
    end
    chk("fill_full", 64'(full), 64'h1);
    chk("fill_oc", 64'(oc(0)), 64'd16);
    chk("fill_err0", 64'(error), 64'd0);
    wr(0, 64'd999);
    chk("ovf_err", 64'(error), 64'd1);
    chk("ovf_oc", 64'(oc(0)), 64'd16);
    chk("ovf_full", 64'(full[0]), 64'd1);
    tick();
    chk("ovf_err_drop", 64'(error), 64'd0);

    rw(0, 64'd777, 64'd100);
    chk("fullrw_err", 64'(error), 64'd1);
    chk("fullrw_oc", 64'(oc(0)), 64'd15);
    chk("fullrw_full", 64'(full[0]), 64'd0);
    for (int i = 1; i < 16; i++) rd(0, 64'(100 + i));
    chk("drain_empty", 64'(empty[0]), 64'd1);

    write_en = 1'b1;
    write_vc = 1'b1;
    data_in = 64'h55;
    read_en = 1'b1;
    read_vc = 1'b1;
    tick();
    idle();
    chk("emptyrw_err", 64'(error), 64'd1);
    chk("emptyrw_oc1", 64'(oc(1)), 64'd1);
    rd(1, 64'h55);

    wr(0, 64'd200);
    for (int i = 0; i < 20; i++) begin
      rw(0, 64'(201 + i), 64'(200 + i));
      chk("wrap_oc", 64'(oc(0)), 64'd1);
    end
    chk("wrap_err", 64'(error), 64'd0);
    rd(0, 64'd220);

    for (int i = 0; i < 5; i++) wr(1, 64'(300 + i));
    chk("mid_oc1", 64'(oc(1)), 64'd5);
    reset = 1'b1;
    write_en = 1'b1;
    write_vc = 1'b1;
    read_vc = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    chk_reset_state();

    w3_en = 1'b1;
    w3_vc = 2'd2;
    d3_in = 8'h42;
    tick();
    idle();
    chk("v3_oc2", 64'(ocup3), 64'(9'd1 << 6));
    chk("v3_err0", 64'(err3), 64'd0);
    w3_en = 1'b1;
    w3_vc = 2'd3;
    d3_in = 8'h99;
    tick();
    idle();
    chk("v3_werr", 64'(err3), 64'd1);
    chk("v3_wocup", 64'(ocup3), 64'(9'd1 << 6));
    chk("v3_wempty", 64'(empty3), 64'h3);
    r3_en = 1'b1;
    r3_vc = 2'd3;
    tick();
    idle();
    chk("v3_rerr", 64'(err3), 64'd1);
    chk("v3_rocup", 64'(ocup3), 64'(9'd1 << 6));
    r3_vc = 2'd2;
`ifdef VC_FIFO_FWFT_EN
    #1;
    chk("v3_data", 64'(d3_out), 64'h42);
`endif
    r3_en = 1'b1;
    tick();
    idle();
`ifndef VC_FIFO_FWFT_EN
    chk("v3_data", 64'(d3_out), 64'h42);
`endif
    chk("v3_rerr_drop", 64'(err3), 64'd0);
    chk("v3_empty", 64'(empty3), 64'h7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
